// File: rtl/parking_lane_arbiter.sv
// Two-lane parking gate arbiter: round-robin lane grant, gate open/close
// sequencing with a wait timeout, and lot occupancy tracking.
module parking_lane_arbiter #(
  parameter int unsigned MAX_SPACES  = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       car_in,
  input  logic       car_out,
  output logic       grant_a,
  output logic       grant_b,
  output logic       open_gate,
  output logic       close_gate,
  output logic [3:0] count,
  output logic       full,
  output logic       alarm_timeout
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SPACES);
  // Leaving OPEN on this value lands the timer on TIMEOUT_CYC-1 at the same edge.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             last_b;
  logic             last_b_nxt;
  logic             car_in_q;
  logic             car_edge;
  logic             win_a;
  logic             grant_a_nxt;
  logic             grant_b_nxt;
  logic             alarm_nxt;

  assign full     = (count == MAX_CNT);
  assign car_edge = car_in & ~car_in_q & (state == OPEN);
  // Lane A wins when alone, or on a tie when B was served last.
  assign win_a    = req_a & (~req_b | last_b);

  // Occupancy: paired entry/exit cancels; saturate at both ends.
  always_comb begin
    count_nxt = count;
    if (car_edge && !car_out) begin
      if (count != MAX_CNT) count_nxt = count + CNT_W'(1);
    end else if (car_out && !car_edge) begin
      if (count != '0) count_nxt = count - CNT_W'(1);
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    last_b_nxt  = last_b;
    grant_a_nxt = 1'b0;
    grant_b_nxt = 1'b0;
    alarm_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!full && (req_a || req_b)) begin
          state_nxt   = GRANT;
          grant_a_nxt = win_a;
          grant_b_nxt = ~win_a;
          last_b_nxt  = ~win_a;
        end
      end
      GRANT: begin
        state_nxt = OPEN;
        timer_nxt = '0;
      end
      OPEN: begin
        timer_nxt = timer + TMR_W'(1);
        if (car_edge) begin
          state_nxt = CLOSE;
        end else if (timer == TMR_LAST) begin
          state_nxt = CLOSE;
          alarm_nxt = 1'b1;
        end
      end
      CLOSE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      count    <= '0;
      last_b   <= 1'b1;
      car_in_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      count    <= count_nxt;
      last_b   <= last_b_nxt;
      car_in_q <= car_in;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_a       <= 1'b0;
      grant_b       <= 1'b0;
      open_gate     <= 1'b0;
      close_gate    <= 1'b1;
      alarm_timeout <= 1'b0;
    end else begin
      grant_a       <= grant_a_nxt;
      grant_b       <= grant_b_nxt;
      open_gate     <= (state_nxt == OPEN);
      close_gate    <= (state_nxt == IDLE) || (state_nxt == CLOSE);
      alarm_timeout <= alarm_nxt;
    end
  end

endmodule

// File: doc/parking_lane_arbiter.md
PARKING_LANE_ARBITER -- requirements
Module: parking_lane_arbiter

Interface
REQ-001 Parameter MAX_SPACES, default 8: lot capacity, legal range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum cycles the gate stays open waiting for a car, legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_a  input  1  lane A access controller holds high after authorizing a car, until granted.
REQ-006 req_b  input  1  lane B access controller holds high after authorizing a car, until granted.
REQ-007 car_in  input  1  entry-passage sensor (level); a rising edge means one car has entered.
REQ-008 car_out  input  1  exit-sensor pulse; each high cycle means one car has left.
REQ-009 grant_a  output  1  one-cycle pulse: lane A owns the gate.
REQ-010 grant_b  output  1  one-cycle pulse: lane B owns the gate.
REQ-011 open_gate  output  1  gate actuator open command.
REQ-012 close_gate  output  1  gate actuator close command.
REQ-013 count  output  4  current occupancy.
REQ-014 full  output  1  high while count == MAX_SPACES.
REQ-015 alarm_timeout  output  1  one-cycle pulse: gate timed out with no car passing.

Function
REQ-016 The FSM SHALL have four states: IDLE, GRANT, OPEN, CLOSE.
REQ-017 In IDLE, with full low and req_a or req_b high, the FSM SHALL select a lane and move to GRANT on the next edge.
- Otherwise it SHALL stay in IDLE.
- Requests arriving while full is high SHALL be held pending, not dropped.
REQ-018 Selection SHALL be round-robin.
- With both requests high, the lane not granted last SHALL win.
- With one request high, that lane SHALL win regardless of history.
REQ-019 In GRANT, the winner's grant pulse SHALL be high for exactly one cycle, then the FSM SHALL move to OPEN.
REQ-020 In OPEN:
- open_gate SHALL be 1 and a wait timer SHALL count cycles from 0.
- A rising edge of car_in SHALL increment count and move the FSM to CLOSE.
- If the timer reaches TIMEOUT_CYC-1 with no car_in edge, alarm_timeout SHALL pulse one cycle, count SHALL be unchanged, and the FSM SHALL move to CLOSE.
REQ-021 In CLOSE, close_gate SHALL be high for one cycle, then the FSM SHALL return to IDLE.
REQ-022 close_gate SHALL be 1 in IDLE and CLOSE and 0 in GRANT and OPEN.
- open_gate SHALL be 1 only in OPEN.
- open_gate and close_gate SHALL never be high together.
REQ-023 car_in edge detection SHALL use a registered copy of car_in.
- Edges outside OPEN SHALL be ignored for counting.
REQ-024 A car_out high cycle SHALL decrement count in any state.
- car_out at count 0 SHALL be ignored (no underflow).
REQ-025 A simultaneous increment and decrement in the same cycle SHALL leave count unchanged.
REQ-026 An increment at count == MAX_SPACES SHALL saturate (count unchanged).
REQ-027 full SHALL be combinationally derived from count.
- A decrement that clears full SHALL let a pending request be granted one cycle after full falls.

Reset
REQ-028 Asserting rst SHALL immediately force all of the following, including mid-operation (e.g. in OPEN):
- state IDLE, timer 0, count 0, last-granted pointer = B (so lane A wins the first tie);
- grant_a, grant_b, open_gate, alarm_timeout, full at 0;
- close_gate at 1.
REQ-029 After rst deasserts, operation SHALL resume from IDLE on the next rising clk edge.

Verification
REQ-030 Basic entry: req_a=1 from reset -> grant_a pulse, then open_gate=1; car_in rises -> close_gate one cycle; count=1.
REQ-031 Tie: req_a=req_b=1 held across two transactions -> grant_a first, then grant_b; neither lane is granted twice in a row.
REQ-032 Timeout: req_b=1, car_in held 0 -> alarm_timeout pulses 15 cycles after OPEN entry (TIMEOUT_CYC=16); count unchanged; FSM returns to IDLE via CLOSE.
REQ-033 Capacity: fill to count=8 -> full=1 and a further req_a gets no grant; one car_out cycle -> count=7, full=0, grant_a follows.
REQ-034 Boundaries: car_out at count=0 -> count stays 0; car_in edge and car_out in the same cycle at count=3 -> count stays 3.
REQ-035 Reset mid-OPEN: rst=1 while open_gate=1 -> open_gate=0, close_gate=1, count=0 without waiting for a clk edge.
